ysyx_23060075_axi_arbiter: RTL and testbench
============================================

Name: ysyx_23060075_axi_arbiter

Overview:
- Two-master to one-slave AXI-lite arbiter sharing the single memory slave (ysyx_23060075_sram) between IFU (m0, read-only) and LSU (m1, read and write).
- One outstanding transaction at a time.
- Round-robin grant, registered in a small FSM; all channel signals are muxed by the current grant.
- Sits between the core's fetch/load-store units and the memory slave.

Parameters:
- W, 32, width of the addr/data/strb/resp fields; matches the `ysyx_23060075_ISA_WIDTH` slave fields.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- m0_araddr/m0_arvalid/m0_arready  in/in/out  W/1/1  IFU read address
- m0_rdata/m0_rresp/m0_rvalid/m0_rready  out/out/out/in  W/W/1/1  IFU read data
- m1_araddr/m1_arvalid/m1_arready  in/in/out  W/1/1  LSU read address
- m1_rdata/m1_rresp/m1_rvalid/m1_rready  out/out/out/in  W/W/1/1  LSU read data
- m1_awaddr/m1_awvalid/m1_awready  in/in/out  W/1/1  LSU write address
- m1_wdata/m1_wstrb/m1_wvalid/m1_wready  in/in/in/out  W/W/1/1  LSU write data
- m1_bresp/m1_bvalid/m1_bready  out/out/in  W/1/1  LSU write response
- s_araddr/s_arvalid/s_arready  out/out/in  W/1/1  slave read address
- s_rdata/s_rresp/s_rvalid/s_rready  in/in/in/out  W/W/1/1  slave read data
- s_awaddr/s_awvalid/s_awready  out/out/in  W/1/1  slave write address
- s_wdata/s_wstrb/s_wvalid/s_wready  out/out/out/in  W/W/1/1  slave write data
- s_bresp/s_bvalid/s_bready  in/in/out  W/1/1  slave write response
- grant  out  2  one-hot current owner {m1,m0}; 0 when idle

Behaviour:
- FSM states: IDLE, RD0 (m0 read), RD1 (m1 read), WR1 (m1 write). Plus a last_m0 flag: 1 means m0 was granted most recently.
- Reset (rst=0, asynchronous): state=IDLE, last_m0=1. While rst=0, every valid/ready output to masters and slave is 0, and grant=0.
- IDLE requests: req0=m0_arvalid; req1r=m1_arvalid; req1w=m1_awvalid|m1_wvalid.
- IDLE transitions:
  - Only m0 requesting -> RD0.
  - Only m1 requesting -> WR1 if req1w, else RD1. LSU write beats LSU read.
  - Both requesting -> m1 if last_m0=1, else RD0.
  - On entering RD0, last_m0<=1; on entering RD1/WR1, last_m0<=0.
- In IDLE all master-side ready/valid outputs are 0 and no request reaches the slave. Arbitration therefore costs exactly 1 cycle: a request seen at edge N is visible on s_* at edge N+1.
- RD0/RD1: owner's ar and r channels connect straight to the slave (s_araddr=mX_araddr, s_arvalid=mX_arvalid, mX_arready=s_arready, mX_rdata/rresp/rvalid=s_*, s_rready=mX_rready). All other outputs are 0.
  - Leave to IDLE on the edge where s_rvalid&&s_rready.
- WR1: aw, w and b channels pass through independently. aw and w may handshake in different cycles, because the slave drops each ready separately.
  - Leave to IDLE on s_bvalid&&s_bready.
- The non-owning master always sees arready/awready/wready/rvalid/bvalid = 0. Data outputs are don't-care, but the bench expects 0 when idle.
- A master that deasserts valid before its handshake while granted: the FSM holds its state until the response completes. No timeout.
- Back-to-back requests: the release edge returns to IDLE, so there is always at least 1 idle cycle between transactions.
- Reset mid-transaction: the FSM aborts to IDLE. An in-flight slave response is not forwarded; a slave reset accompanies this by design.
- grant is combinational from state: RD0=01, RD1/WR1=10, IDLE=00.

Decomposition:
- Shared package/header holds:
  - state encoding constants (ARB_IDLE=2'd0, ARB_RD0=2'd1, ARB_RD1=2'd2, ARB_WR1=2'd3);
  - master index constants (IFU=0, LSU=1).
- One sub-module, ysyx_23060075_rr_arb2: a 2-requester round-robin picker with a last-grant register. It takes req0/req1 and an enable, and outputs a one-hot pick.

Test Plan:
- m0_arvalid=1, addr=0x80000000, slave rvalid 3 cycles after arready, rdata=0xDEADBEEF -> grant=01 one cycle after request; m0_rdata=0xDEADBEEF with m0_rvalid; m1_arready stays 0; back to grant=00 after r handshake.
- m0 and m1 both assert arvalid on the same cycle after reset (last_m0=1) -> m1 is served first (grant=10); m0 is granted on the next IDLE; the order alternates for 4 consecutive paired requests.
- m1 awvalid and wvalid together, slave awready on cycle 1 and wready on cycle 3, bvalid 2 cycles later -> s_wstrb=m1_wstrb=0xF; m1_bvalid is pulsed; m0 is stalled throughout; state returns to IDLE.
- m1 asserts both awvalid and arvalid in IDLE -> WR1 is taken first, then RD1.
- rst driven low mid-RD0 (slave rvalid not yet seen) -> grant=00 and all ready/valid outputs are 0 immediately; after rst goes high, a new m1 request is granted within 1 cycle.
- Random slave latency 1-5 cycles, 1000 mixed requests -> each master receives exactly its own responses in order; no response is lost or duplicated.

Source files
------------

// File: rtl/ysyx_23060075_axi_arbiter_pkg.sv
// Shared definitions for the IFU/LSU AXI-lite arbiter: FSM state encoding,
// master indices and the state-to-grant decode.
package ysyx_23060075_axi_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD0  = 2'd1,
        ARB_RD1  = 2'd2,
        ARB_WR1  = 2'd3
    } arb_state_e;

    localparam int IFU = 0;
    localparam int LSU = 1;

    // One-hot owner {m1,m0}; zero while idle.
    function automatic logic [1:0] grant_of(input arb_state_e s);
        case (s)
            ARB_RD0:          grant_of = 2'b01;
            ARB_RD1, ARB_WR1: grant_of = 2'b10;
            default:          grant_of = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_23060075_rr_arb2.sv
// Two-requester round-robin picker. The last-grant flag remembers whether
// requester 0 (IFU) won most recently; ties go to the other requester.
module ysyx_23060075_rr_arb2
    import ysyx_23060075_axi_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       req0,
    input  logic       req1,
    output logic [1:0] pick
);

    logic last_m0_reg;

    always_comb begin
        pick = 2'b00;
        if (en) begin
            if (req0 && req1) begin
                pick = last_m0_reg ? 2'b10 : 2'b01;
            end else begin
                pick = {req1, req0};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_m0_reg <= 1'b1;
        end else if (pick[IFU]) begin
            last_m0_reg <= 1'b1;
        end else if (pick[LSU]) begin
            last_m0_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/ysyx_23060075_axi_arbiter.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI-lite arbiter.
// One transaction in flight; the owner's channels are muxed straight through.
module ysyx_23060075_axi_arbiter
    import ysyx_23060075_axi_arbiter_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,

    input  logic [W-1:0] m0_araddr,
    input  logic         m0_arvalid,
    output logic         m0_arready,
    output logic [W-1:0] m0_rdata,
    output logic [W-1:0] m0_rresp,
    output logic         m0_rvalid,
    input  logic         m0_rready,

    input  logic [W-1:0] m1_araddr,
    input  logic         m1_arvalid,
    output logic         m1_arready,
    output logic [W-1:0] m1_rdata,
    output logic [W-1:0] m1_rresp,
    output logic         m1_rvalid,
    input  logic         m1_rready,
    input  logic [W-1:0] m1_awaddr,
    input  logic         m1_awvalid,
    output logic         m1_awready,
    input  logic [W-1:0] m1_wdata,
    input  logic [W-1:0] m1_wstrb,
    input  logic         m1_wvalid,
    output logic         m1_wready,
    output logic [W-1:0] m1_bresp,
    output logic         m1_bvalid,
    input  logic         m1_bready,

    output logic [W-1:0] s_araddr,
    output logic         s_arvalid,
    input  logic         s_arready,
    input  logic [W-1:0] s_rdata,
    input  logic [W-1:0] s_rresp,
    input  logic         s_rvalid,
    output logic         s_rready,
    output logic [W-1:0] s_awaddr,
    output logic         s_awvalid,
    input  logic         s_awready,
    output logic [W-1:0] s_wdata,
    output logic [W-1:0] s_wstrb,
    output logic         s_wvalid,
    input  logic         s_wready,
    input  logic [W-1:0] s_bresp,
    input  logic         s_bvalid,
    output logic         s_bready,

    output logic [1:0]   grant
);

    arb_state_e state_reg;
    logic [1:0] pick;
    logic       req1w;

    assign req1w = m1_awvalid | m1_wvalid;

    ysyx_23060075_rr_arb2 u_rr (
        .clk  (clk),
        .rst  (rst),
        .en   (state_reg == ARB_IDLE),
        .req0 (m0_arvalid),
        .req1 (m1_arvalid | req1w),
        .pick (pick)
    );

    // Arbitration takes the single IDLE cycle; release always passes back
    // through IDLE so consecutive transactions are separated by one cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= ARB_IDLE;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (pick[IFU]) begin
                        state_reg <= ARB_RD0;
                    end else if (pick[LSU]) begin
                        state_reg <= req1w ? ARB_WR1 : ARB_RD1;
                    end
                end
                ARB_RD0, ARB_RD1: begin
                    if (s_rvalid && s_rready) state_reg <= ARB_IDLE;
                end
                ARB_WR1: begin
                    if (s_bvalid && s_bready) state_reg <= ARB_IDLE;
                end
                default: state_reg <= ARB_IDLE;
            endcase
        end
    end

    assign grant = grant_of(state_reg);

    always_comb begin
        m0_arready = 1'b0;
        m0_rdata   = '0;
        m0_rresp   = '0;
        m0_rvalid  = 1'b0;
        m1_arready = 1'b0;
        m1_rdata   = '0;
        m1_rresp   = '0;
        m1_rvalid  = 1'b0;
        m1_awready = 1'b0;
        m1_wready  = 1'b0;
        m1_bresp   = '0;
        m1_bvalid  = 1'b0;
        s_araddr   = '0;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        s_awaddr   = '0;
        s_awvalid  = 1'b0;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_wvalid   = 1'b0;
        s_bready   = 1'b0;
        case (state_reg)
            ARB_RD0: begin
                s_araddr   = m0_araddr;
                s_arvalid  = m0_arvalid;
                m0_arready = s_arready;
                m0_rdata   = s_rdata;
                m0_rresp   = s_rresp;
                m0_rvalid  = s_rvalid;
                s_rready   = m0_rready;
            end
            ARB_RD1: begin
                s_araddr   = m1_araddr;
                s_arvalid  = m1_arvalid;
                m1_arready = s_arready;
                m1_rdata   = s_rdata;
                m1_rresp   = s_rresp;
                m1_rvalid  = s_rvalid;
                s_rready   = m1_rready;
            end
            ARB_WR1: begin
                // aw and w complete independently; the slave drops each ready on its own.
                s_awaddr   = m1_awaddr;
                s_awvalid  = m1_awvalid;
                m1_awready = s_awready;
                s_wdata    = m1_wdata;
                s_wstrb    = m1_wstrb;
                s_wvalid   = m1_wvalid;
                m1_wready  = s_wready;
                m1_bresp   = s_bresp;
                m1_bvalid  = s_bvalid;
                s_bready   = m1_bready;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ysyx_23060075_axi_arbiter.sv
// Bench for the IFU/LSU AXI-lite arbiter: arbitration table, directed
// multi-cycle sequences and a randomized run against a per-master queue model.
module tb_ysyx_23060075_axi_arbiter;

    localparam int W    = 32;
    localparam int NREQ = 1000;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] m0_araddr, m0_rdata, m0_rresp;
    logic         m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [W-1:0] m1_araddr, m1_rdata, m1_rresp, m1_awaddr, m1_wdata, m1_wstrb, m1_bresp;
    logic         m1_arvalid, m1_arready, m1_rvalid, m1_rready;
    logic         m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
    logic [W-1:0] s_araddr, s_rdata, s_rresp, s_awaddr, s_wdata, s_wstrb, s_bresp;
    logic         s_arvalid, s_arready, s_rvalid, s_rready;
    logic         s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic [1:0]   grant;

    ysyx_23060075_axi_arbiter #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .m0_araddr(m0_araddr), .m0_arvalid(m0_arvalid), .m0_arready(m0_arready),
        .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m1_araddr(m1_araddr), .m1_arvalid(m1_arvalid), .m1_arready(m1_arready),
        .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_awaddr(m1_awaddr), .m1_awvalid(m1_awvalid), .m1_awready(m1_awready),
        .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wvalid(m1_wvalid), .m1_wready(m1_wready),
        .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .grant(grant)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        m0_araddr = '0; m0_arvalid = 0; m0_rready = 0;
        m1_araddr = '0; m1_arvalid = 0; m1_rready = 0;
        m1_awaddr = '0; m1_awvalid = 0; m1_wdata = '0; m1_wstrb = '0;
        m1_wvalid = 0; m1_bready = 0;
        s_arready = 0; s_rdata = '0; s_rresp = '0; s_rvalid = 0;
        s_awready = 0; s_wready = 0; s_bresp = '0; s_bvalid = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
    endtask

    // A complete LSU read, leaving the round-robin flag pointing away from m1.
    task automatic lsu_read_once();
        m1_arvalid = 1; m1_rready = 1;
        step();
        s_arready = 1; s_rvalid = 1;
        step();
        clear_inputs();
        #1 chk("prior_release", {30'b0, grant}, 32'h0);
    endtask

    // Slave-side reference behaviour: responses derived from the request.
    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction
    function automatic logic [31:0] rresp_fn(input logic [31:0] a);
        return {a[15:0], a[31:16]};
    endfunction
    function automatic logic [31:0] bresp_fn(input logic [31:0] a, input logic [31:0] d,
                                             input logic [31:0] s);
        return a ^ {d[15:0], d[31:16]} ^ s;
    endfunction

    typedef struct {
        logic       m0a, m1a, m1aw, m1w, prior_m1;
        logic [1:0] g;
        logic       sar, saw, sw;
    } vec_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] resp;
    } exp_t;

    vec_t vecs[10];
    exp_t q0[$], q1[$];

    // Randomized-phase state (used by the single stimulus process only).
    int          issued, done0, done1, last_owner, cyc, sl_rcnt, sl_bcnt;
    logic        pend_exp, m0_busy, m1_busy, sl_rbusy, sl_aw_got, sl_w_got, sl_bbusy;
    logic [1:0]  exp_g, g;
    logic        h0ar, h0r, h1ar, h1r, h1aw, h1w, h1b, hsar, hsr, hsaw, hsw, hsb;
    logic [31:0] c_rd0, c_rr0, c_rd1, c_rr1, c_b1, c_sar, c_saw, c_sw, c_ss;
    logic [31:0] sl_raddr, sl_waddr, sl_wdata, sl_wstrb, a, d, s;
    exp_t        e;

    initial begin
        //            m0a m1a aw  w  prior  grant  sar saw sw
        vecs[0] = '{1, 0, 0, 0, 0, 2'b01, 1, 0, 0};
        vecs[1] = '{0, 1, 0, 0, 0, 2'b10, 1, 0, 0};
        vecs[2] = '{0, 0, 1, 0, 0, 2'b10, 0, 1, 0};
        vecs[3] = '{0, 0, 0, 1, 0, 2'b10, 0, 0, 1};
        vecs[4] = '{0, 1, 1, 0, 0, 2'b10, 0, 1, 0};
        vecs[5] = '{1, 1, 0, 0, 0, 2'b10, 1, 0, 0};
        vecs[6] = '{1, 1, 0, 0, 1, 2'b01, 1, 0, 0};
        vecs[7] = '{1, 0, 1, 1, 1, 2'b01, 1, 0, 0};
        vecs[8] = '{0, 0, 0, 0, 0, 2'b00, 0, 0, 0};
        vecs[9] = '{1, 0, 0, 1, 0, 2'b10, 0, 0, 1};

        rst = 1'b0;
        clear_inputs();
        #2;
        chk("reset_grant", {30'b0, grant}, 32'h0);
        chk("reset_valids", {28'b0, s_arvalid, s_awvalid, s_wvalid, s_rready}, 32'h0);

        // ---------------- arbitration table ----------------
        for (int i = 0; i < 10; i++) begin
            do_reset();
            if (vecs[i].prior_m1) lsu_read_once();
            m0_araddr  = 32'h1000_0000 | i;
            m1_araddr  = 32'h2000_0000 | i;
            m0_arvalid = vecs[i].m0a;
            m1_arvalid = vecs[i].m1a;
            m1_awvalid = vecs[i].m1aw;
            m1_wvalid  = vecs[i].m1w;
            #1;
            chk("vec_idle_grant", {30'b0, grant}, 32'h0);
            chk("vec_idle_sar", {31'b0, s_arvalid}, 32'h0);
            step();
            chk("vec_grant", {30'b0, grant}, {30'b0, vecs[i].g});
            chk("vec_s_valids", {29'b0, s_arvalid, s_awvalid, s_wvalid},
                {29'b0, vecs[i].sar, vecs[i].saw, vecs[i].sw});
            $display("vec %0d grant=%b s_ar/aw/w=%b%b%b", i, grant, s_arvalid, s_awvalid, s_wvalid);
        end

        // ---------------- IFU read, slave answers 3 cycles later ----------------
        do_reset();
        m0_araddr = 32'h8000_0000; m0_arvalid = 1; m0_rready = 1;
        #1 chk("a_idle_grant", {30'b0, grant}, 32'h0);
        step();
        chk("a_grant", {30'b0, grant}, 32'h1);
        chk("a_s_araddr", s_araddr, 32'h8000_0000);
        s_arready = 1;
        #1 chk("a_m0_arready", {31'b0, m0_arready}, 32'h1);
        chk("a_m1_arready", {31'b0, m1_arready}, 32'h0);
        step();
        m0_arvalid = 0; s_arready = 0;
        repeat (2) begin
            step();
            chk("a_wait_rvalid", {31'b0, m0_rvalid}, 32'h0);
        end
        s_rvalid = 1; s_rdata = 32'hDEAD_BEEF;
        #1 chk("a_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
        chk("a_m0_rvalid", {31'b0, m0_rvalid}, 32'h1);
        chk("a_m1_rvalid", {31'b0, m1_rvalid}, 32'h0);
        step();
        s_rvalid = 0;
        #1 chk("a_release", {30'b0, grant}, 32'h0);
        chk("a_idle_rdata", m0_rdata, 32'h0);
        $display("txn directed m0 read 80000000 -> deadbeef");

        // ---------------- LSU write with split aw/w handshakes ----------------
        do_reset();
        m0_araddr = 32'h8000_0010; m0_arvalid = 1; m0_rready = 1;
        m1_awaddr = 32'h8000_0100; m1_awvalid = 1;
        m1_wdata = 32'hCAFE_F00D; m1_wstrb = 32'hF; m1_wvalid = 1; m1_bready = 1;
        step();
        chk("b_grant", {30'b0, grant}, 32'h2);
        chk("b_s_wstrb", s_wstrb, 32'hF);
        s_awready = 1;
        #1 chk("b_awready", {30'b0, m1_awready, m1_wready}, 32'h2);
        step();
        m1_awvalid = 0; s_awready = 0;
        step();
        chk("b_m0_stalled", {30'b0, m0_arready, s_arvalid}, 32'h0);
        s_wready = 1;
        #1 chk("b_wready", {31'b0, m1_wready}, 32'h1);
        chk("b_s_wdata", s_wdata, 32'hCAFE_F00D);
        step();
        m1_wvalid = 0; s_wready = 0;
        step();
        chk("b_no_bvalid", {31'b0, m1_bvalid}, 32'h0);
        step();
        s_bvalid = 1; s_bresp = 32'h0;
        #1 chk("b_bvalid", {30'b0, m1_bvalid, s_bready}, 32'h3);
        chk("b_grant_hold", {30'b0, grant}, 32'h2);
        step();
        s_bvalid = 0;
        #1 chk("b_release", {30'b0, grant}, 32'h0);
        chk("b_bvalid_drop", {31'b0, m1_bvalid}, 32'h0);
        step();
        chk("b_m0_next", {30'b0, grant}, 32'h1);
        $display("txn directed m1 write 80000100 <- cafef00d");

        // ---------------- LSU write takes precedence over LSU read ----------------
        do_reset();
        m1_arvalid = 1; m1_rready = 1; m1_awvalid = 1; m1_wvalid = 1; m1_bready = 1;
        step();
        chk("c_wr_first", {29'b0, grant, s_arvalid}, {29'b0, 2'b10, 1'b0});
        chk("c_s_awvalid", {31'b0, s_awvalid}, 32'h1);
        s_awready = 1; s_wready = 1;
        step();
        m1_awvalid = 0; m1_wvalid = 0; s_awready = 0; s_wready = 0; s_bvalid = 1;
        step();
        s_bvalid = 0;
        #1 chk("c_idle", {30'b0, grant}, 32'h0);
        step();
        chk("c_rd_second", {29'b0, grant, s_arvalid}, {29'b0, 2'b10, 1'b1});

        // ---------------- paired reads alternate m1, m0, m1, m0 ----------------
        do_reset();
        for (int k = 0; k < 4; k++) begin
            m0_arvalid = 1; m1_arvalid = 1; m0_rready = 1; m1_rready = 1;
            for (int j = 0; j < 2; j++) begin
                step();
                chk("d_order", {30'b0, grant}, (j == 0) ? 32'h2 : 32'h1);
                s_arready = 1; s_rvalid = 1; s_rdata = 32'h100 + k * 2 + j;
                #1;
                if (j == 0) chk("d_m1_rdata", m1_rdata, 32'h100 + k * 2);
                else        chk("d_m0_rdata", m0_rdata, 32'h100 + k * 2 + 1);
                step();
                s_arready = 0; s_rvalid = 0;
                if (j == 0) m1_arvalid = 0;
                else        m0_arvalid = 0;
            end
        end

        // ---------------- reset in the middle of an IFU read ----------------
        do_reset();
        m0_araddr = 32'h8000_0020; m0_arvalid = 1; m0_rready = 1;
        step();
        chk("e_grant", {30'b0, grant}, 32'h1);
        s_arready = 1;
        step();
        m0_arvalid = 0;
        rst = 0; s_rvalid = 1;
        #1 chk("e_rst_grant", {30'b0, grant}, 32'h0);
        chk("e_rst_valids", {28'b0, m0_arready, m0_rvalid, s_rready, s_arvalid}, 32'h0);
        clear_inputs();
        step();
        rst = 1;
        m1_arvalid = 1; m1_rready = 1;
        step();
        chk("e_m1_after_rst", {30'b0, grant}, 32'h2);

        // ---------------- randomized mixed traffic ----------------
        do_reset();
        issued = 0; done0 = 0; done1 = 0; cyc = 0; last_owner = 0; pend_exp = 0;
        m0_busy = 0; m1_busy = 0;
        sl_rbusy = 0; sl_aw_got = 0; sl_w_got = 0; sl_bbusy = 0; sl_rcnt = 0; sl_bcnt = 0;
        sl_raddr = '0; sl_waddr = '0; sl_wdata = '0; sl_wstrb = '0;
        while ((issued < NREQ || m0_busy || m1_busy) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            g = grant;
            if (pend_exp) chk("arb_grant", {30'b0, g}, {30'b0, exp_g});
            pend_exp = 0;
            if (g == 2'b00) begin
                if (m0_arvalid && (m1_arvalid || m1_awvalid || m1_wvalid))
                    exp_g = (last_owner == 0) ? 2'b10 : 2'b01;
                else if (m0_arvalid) exp_g = 2'b01;
                else if (m1_arvalid || m1_awvalid || m1_wvalid) exp_g = 2'b10;
                else exp_g = 2'b00;
                if (exp_g == 2'b01) last_owner = 0;
                if (exp_g == 2'b10) last_owner = 1;
                pend_exp = 1;
            end
            if (g != 2'b01) chk("m0_isolated", {30'b0, m0_arready, m0_rvalid}, 32'h0);
            if (g != 2'b10)
                chk("m1_isolated", {27'b0, m1_arready, m1_rvalid, m1_awready, m1_wready, m1_bvalid}, 32'h0);
            h0ar = m0_arvalid & m0_arready; h0r = m0_rvalid & m0_rready;
            h1ar = m1_arvalid & m1_arready; h1r = m1_rvalid & m1_rready;
            h1aw = m1_awvalid & m1_awready; h1w = m1_wvalid & m1_wready;
            h1b  = m1_bvalid & m1_bready;
            hsar = s_arvalid & s_arready;   hsr = s_rvalid & s_rready;
            hsaw = s_awvalid & s_awready;   hsw = s_wvalid & s_wready;
            hsb  = s_bvalid & s_bready;
            c_rd0 = m0_rdata; c_rr0 = m0_rresp; c_rd1 = m1_rdata; c_rr1 = m1_rresp;
            c_b1 = m1_bresp; c_sar = s_araddr; c_saw = s_awaddr; c_sw = s_wdata; c_ss = s_wstrb;

            if (h0r) begin
                if (q0.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL m0_spurious_resp actual=%0h required=none", c_rd0);
                end else begin
                    e = q0.pop_front();
                    chk("m0_rdata", c_rd0, e.data);
                    chk("m0_rresp", c_rr0, e.resp);
                    done0++;
                    $display("txn m0 rd addr=%h data=%h", e.addr, c_rd0);
                end
            end
            if (h1r || h1b) begin
                if (q1.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL m1_spurious_resp actual=%0h required=none", h1b ? c_b1 : c_rd1);
                end else begin
                    e = q1.pop_front();
                    chk("m1_kind", {31'b0, h1b}, {31'b0, e.wr});
                    if (h1b) chk("m1_bresp", c_b1, e.resp);
                    else begin
                        chk("m1_rdata", c_rd1, e.data);
                        chk("m1_rresp", c_rr1, e.resp);
                    end
                    done1++;
                    $display("txn m1 %s addr=%h data=%h", e.wr ? "wr" : "rd", e.addr,
                             h1b ? c_b1 : c_rd1);
                end
            end

            @(posedge clk);
            #1;
            // masters
            if (h0ar) m0_arvalid = 0;
            if (h0r)  m0_busy = 0;
            if (h1ar) m1_arvalid = 0;
            if (h1aw) m1_awvalid = 0;
            if (h1w)  m1_wvalid = 0;
            if (h1r || h1b) m1_busy = 0;
            m0_rready = ($urandom_range(0, 3) != 0);
            m1_rready = ($urandom_range(0, 3) != 0);
            m1_bready = ($urandom_range(0, 3) != 0);
            if (!m0_busy && issued < NREQ && $urandom_range(0, 2) == 0) begin
                a = $urandom & 32'hFFFF_FFFC;
                m0_araddr = a; m0_arvalid = 1; m0_busy = 1; issued++;
                q0.push_back('{1'b0, a, rd_fn(a), rresp_fn(a)});
            end
            if (!m1_busy && issued < NREQ && $urandom_range(0, 2) == 0) begin
                a = $urandom & 32'hFFFF_FFFC;
                m1_busy = 1; issued++;
                if ($urandom_range(0, 1) == 1) begin
                    d = $urandom; s = $urandom_range(1, 15);
                    m1_awaddr = a; m1_wdata = d; m1_wstrb = s;
                    m1_awvalid = 1; m1_wvalid = 1;
                    q1.push_back('{1'b1, a, d, bresp_fn(a, d, s)});
                end else begin
                    m1_araddr = a; m1_arvalid = 1;
                    q1.push_back('{1'b0, a, rd_fn(a), rresp_fn(a)});
                end
            end
            // slave read side
            if (hsar) begin sl_rbusy = 1; sl_rcnt = $urandom_range(1, 5); sl_raddr = c_sar; end
            if (hsr)  begin s_rvalid = 0; sl_rbusy = 0; end
            if (sl_rbusy && !s_rvalid) begin
                sl_rcnt--;
                if (sl_rcnt == 0) begin
                    s_rvalid = 1; s_rdata = rd_fn(sl_raddr); s_rresp = rresp_fn(sl_raddr);
                end
            end
            s_arready = !sl_rbusy && ($urandom_range(0, 1) == 1);
            // slave write side
            if (hsb) begin s_bvalid = 0; sl_bbusy = 0; sl_aw_got = 0; sl_w_got = 0; end
            if (hsaw) begin sl_aw_got = 1; sl_waddr = c_saw; end
            if (hsw)  begin sl_w_got = 1; sl_wdata = c_sw; sl_wstrb = c_ss; end
            if (sl_aw_got && sl_w_got && !sl_bbusy) begin
                sl_bbusy = 1; sl_bcnt = $urandom_range(1, 5);
            end
            if (sl_bbusy && !s_bvalid) begin
                sl_bcnt--;
                if (sl_bcnt == 0) begin
                    s_bvalid = 1; s_bresp = bresp_fn(sl_waddr, sl_wdata, sl_wstrb);
                end
            end
            s_awready = !sl_aw_got && ($urandom_range(0, 1) == 1);
            s_wready  = !sl_w_got && ($urandom_range(0, 1) == 1);
        end
        chk("rand_drained", {30'b0, m0_busy, m1_busy}, 32'h0);
        chk("rand_resp_count", done0 + done1, issued);
        chk("rand_queues_empty", q0.size() + q1.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
